// File: rtl/ant_nav_ctrl.sv
// ant_nav_ctrl: registered wall-following maze controller with selectable follow
// side, saturating visit-count pheromone, collision backoff, stuck/loop side
// flipping and a sticky escape flag.
module ant_nav_ctrl #(
  parameter int unsigned PH_WIDTH    = 2,
  parameter bit          FOLLOW_SIDE = 1'b0,
  parameter int unsigned STUCK_LIMIT = 8,
  parameter int unsigned BACKOFF_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ant_l,
  input  logic                ant_r,
  input  logic                hit,
  input  logic                escape,
  input  logic [PH_WIDTH-1:0] ph_detected,
  output logic [1:0]          move,
  output logic [PH_WIDTH-1:0] ph_drop,
  output logic                side,
  output logic                done
);

  localparam int unsigned STUCK_W = $clog2(STUCK_LIMIT + 1);
  localparam int unsigned BO_W    = $clog2(BACKOFF_CYC + 1);

  localparam logic [PH_WIDTH-1:0] PH_MAX = {PH_WIDTH{1'b1}};

  localparam logic [1:0] HALT    = 2'b00;
  localparam logic [1:0] RIGHT   = 2'b01;
  localparam logic [1:0] LEFT    = 2'b10;
  localparam logic [1:0] FORWARD = 2'b11;

  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_LIMIT - 1);
  localparam logic [BO_W-1:0]    BO_RELOAD  = BO_W'(BACKOFF_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SEEK,
    ST_SETTLE,
    ST_BACKOFF,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            move_q, move_d;
  logic [PH_WIDTH-1:0]   ph_drop_q, ph_drop_d;
  logic                  side_q, side_d;
  logic                  done_q, done_d;
  logic [STUCK_W-1:0]    stuck_q, stuck_d;
  logic [BO_W-1:0]       bo_q, bo_d;

  logic                  near, far;
  logic [1:0]            toward, away;
  logic                  flip;

  // Side-relative view of the antennae and turns for the current follow side.
  always_comb begin
    near   = side_q ? ant_r : ant_l;
    far    = side_q ? ant_l : ant_r;
    toward = side_q ? RIGHT : LEFT;
    away   = side_q ? LEFT  : RIGHT;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      move_q    <= HALT;
      ph_drop_q <= '0;
      side_q    <= FOLLOW_SIDE;
      done_q    <= 1'b0;
      stuck_q   <= '0;
      bo_q      <= '0;
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      ph_drop_q <= ph_drop_d;
      side_q    <= side_d;
      done_q    <= done_d;
      stuck_q   <= stuck_d;
      bo_q      <= bo_d;
    end
  end

  // Next-state, move decision, pheromone deposit and side-flip bookkeeping.
  always_comb begin
    state_d   = state_q;
    move_d    = HALT;
    bo_d      = bo_q;
    ph_drop_d = '0;
    stuck_d   = stuck_q;
    flip      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_SEEK, ST_SETTLE: begin
        if (escape) begin
          state_d = ST_DONE;
        end else if (hit) begin
          state_d = ST_BACKOFF;
          bo_d    = BO_RELOAD;
        end else if (state_q == ST_SETTLE) begin
          state_d = ST_RUN;
        end else if (far) begin
          move_d  = away;
          state_d = ST_SETTLE;
        end else if (near || (state_q == ST_SEEK)) begin
          move_d  = FORWARD;
          state_d = ST_RUN;
        end else begin
          move_d  = toward;
          state_d = ST_SEEK;
        end
      end
      ST_BACKOFF: begin
        if (escape) begin
          state_d = ST_DONE;
        end else if (hit) begin
          bo_d = BO_RELOAD;
        end else if (bo_q != '0) begin
          bo_d = bo_q - BO_W'(1);
        end else begin
          move_d  = away;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deposit one more than the detected level, saturating, only on FORWARD.
    if (move_d == FORWARD) begin
      ph_drop_d = (ph_detected == PH_MAX) ? PH_MAX : ph_detected + PH_WIDTH'(1);
    end

    // Stuck counting and loop detection; FORWARD and non-FORWARD are exclusive,
    // so at most one flip source fires per edge.
    if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      if (move_d == FORWARD) begin
        stuck_d = '0;
        flip    = (ph_detected == PH_MAX);
      end else if (stuck_q == STUCK_LAST) begin
        stuck_d = '0;
        flip    = 1'b1;
      end else begin
        stuck_d = stuck_q + STUCK_W'(1);
      end
    end

    side_d = side_q ^ flip;
    done_d = (state_d == ST_DONE);
  end

  assign move    = move_q;
  assign ph_drop = ph_drop_q;
  assign side    = side_q;
  assign done    = done_q;

endmodule
